// File: rtl/dpram_ctrl_pkg.sv
// Shared widths, request struct and port-select enum for the dual-port RAM front-end.
package dpram_ctrl_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_sel_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;
endpackage

// File: rtl/dpram_port_ctrl_if.sv
// Client request/response ports plus RAM pins; slave = controller side, master = clients + RAM.
interface dpram_port_ctrl_if;
  import dpram_ctrl_pkg::*;

  logic              req_a_valid, req_a_ready, req_a_we;
  logic [ADDR_W-1:0] req_a_addr;
  logic [DATA_W-1:0] req_a_wdata;
  logic              rsp_a_valid;
  logic [DATA_W-1:0] rsp_a_rdata;
  logic              req_b_valid, req_b_ready, req_b_we;
  logic [ADDR_W-1:0] req_b_addr;
  logic [DATA_W-1:0] req_b_wdata;
  logic              rsp_b_valid;
  logic [DATA_W-1:0] rsp_b_rdata;
  logic [ADDR_W-1:0] ram_addr_a, ram_addr_b;
  logic              ram_we_a, ram_we_b;
  logic [DATA_W-1:0] ram_data_a, ram_data_b;
  logic [DATA_W-1:0] ram_dataout_a, ram_dataout_b;

  modport slave (
    input  req_a_valid, req_a_we, req_a_addr, req_a_wdata,
    input  req_b_valid, req_b_we, req_b_addr, req_b_wdata,
    output req_a_ready, rsp_a_valid, rsp_a_rdata,
    output req_b_ready, rsp_b_valid, rsp_b_rdata,
    output ram_addr_a, ram_addr_b, ram_we_a, ram_we_b, ram_data_a, ram_data_b,
    input  ram_dataout_a, ram_dataout_b
  );

  modport master (
    output req_a_valid, req_a_we, req_a_addr, req_a_wdata,
    output req_b_valid, req_b_we, req_b_addr, req_b_wdata,
    input  req_a_ready, rsp_a_valid, rsp_a_rdata,
    input  req_b_ready, rsp_b_valid, rsp_b_rdata,
    input  ram_addr_a, ram_addr_b, ram_we_a, ram_we_b, ram_data_a, ram_data_b,
    output ram_dataout_a, ram_dataout_b
  );
endinterface

// File: rtl/dpram_conflict_arb.sv
// Same-address hazard detection, ready generation and the priority pointer.
// DPRAM_RR_ARB_EN selects round-robin; otherwise port A always wins.
module dpram_conflict_arb
  import dpram_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  req_t       req_a,
  input  req_t       req_b,
  output logic [1:0] ready
);
  port_sel_e pri_q, pri_d;
  logic      conflict;

  // Two reads of one address are harmless; only a write makes it a hazard.
  assign conflict = valid[0] & valid[1] & (req_a.addr == req_b.addr) & (req_a.we | req_b.we);

  always_comb begin
    ready = 2'b11;
    if (conflict) ready = (pri_q == PORT_A) ? 2'b01 : 2'b10;
    if (rst)      ready = 2'b00;
  end

  always_comb begin
    pri_d = pri_q;
`ifdef DPRAM_RR_ARB_EN
    if (conflict) pri_d = (pri_q == PORT_A) ? PORT_B : PORT_A;
`else
    pri_d = PORT_A;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pri_q <= PORT_A;
    else     pri_q <= pri_d;
  end
endmodule

// File: rtl/dpram_port_ctrl.sv
// Dual-port RAM request front-end: arbitration, registered RAM pin drive, read tracking.
// Optional DPRAM_RR_ARB_EN enables round-robin conflict arbitration.
module dpram_port_ctrl
  import dpram_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  dpram_port_ctrl_if.slave  bus
);
  req_t                   req_p [2];
  logic [1:0]             vld, rdy, fire;
  logic [1:0][ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [1:0]             ram_we_q, ram_we_d;
  logic [1:0][DATA_W-1:0] ram_data_q, ram_data_d;
  logic [1:0]             rd_iss_q, rd_iss_d;
  logic [1:0]             rsp_vld_q, rsp_vld_d;

  assign req_p[0] = {bus.req_a_we, bus.req_a_addr, bus.req_a_wdata};
  assign req_p[1] = {bus.req_b_we, bus.req_b_addr, bus.req_b_wdata};
  assign vld      = {bus.req_b_valid, bus.req_a_valid};
  assign fire     = vld & rdy;

  dpram_conflict_arb u_arb (
    .clk   (clk),
    .rst   (rst),
    .valid (vld),
    .req_a (req_p[0]),
    .req_b (req_p[1]),
    .ready (rdy)
  );

  always_comb begin
    ram_addr_d = ram_addr_q;
    ram_we_d   = '0;
    ram_data_d = '0;
    rd_iss_d   = '0;
    for (int p = 0; p < 2; p++) begin
      if (fire[p]) begin
        ram_addr_d[p] = req_p[p].addr;
        ram_we_d[p]   = req_p[p].we;
        ram_data_d[p] = req_p[p].wdata;
        rd_iss_d[p]   = ~req_p[p].we;
      end
    end
    rsp_vld_d = rd_iss_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_addr_q <= '0;
      ram_we_q   <= '0;
      ram_data_q <= '0;
      rd_iss_q   <= '0;
      rsp_vld_q  <= '0;
    end else begin
      ram_addr_q <= ram_addr_d;
      ram_we_q   <= ram_we_d;
      ram_data_q <= ram_data_d;
      rd_iss_q   <= rd_iss_d;
      rsp_vld_q  <= rsp_vld_d;
    end
  end

  assign bus.req_a_ready = rdy[0];
  assign bus.req_b_ready = rdy[1];
  assign bus.ram_addr_a  = ram_addr_q[0];
  assign bus.ram_addr_b  = ram_addr_q[1];
  assign bus.ram_we_a    = ram_we_q[0];
  assign bus.ram_we_b    = ram_we_q[1];
  assign bus.ram_data_a  = ram_data_q[0];
  assign bus.ram_data_b  = ram_data_q[1];
  // RAM output register is the data stage; only the valid is ours.
  assign bus.rsp_a_valid = rsp_vld_q[0];
  assign bus.rsp_b_valid = rsp_vld_q[1];
  assign bus.rsp_a_rdata = rsp_vld_q[0] ? bus.ram_dataout_a : '0;
  assign bus.rsp_b_rdata = rsp_vld_q[1] ? bus.ram_dataout_b : '0;
endmodule

// File: tb/tb_dpram_port_ctrl.sv
// Directed bench for dpram_port_ctrl with a behavioural registered-read dual-port RAM.
module tb_dpram_port_ctrl;
  logic clk, rst, mem_init;
  int   n_chk, n_pass;
  logic [15:0] mem [256];

  dpram_port_ctrl_if bus ();
  dpram_port_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
      mem[8'h05] <= 16'hA5A5;
    end else begin
      if (bus.ram_we_a) mem[bus.ram_addr_a] <= bus.ram_data_a;
      if (bus.ram_we_b) mem[bus.ram_addr_b] <= bus.ram_data_b;
    end
    bus.ram_dataout_a <= mem[bus.ram_addr_a];
    bus.ram_dataout_b <= mem[bus.ram_addr_b];
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic set_a(input logic v, input logic we, input logic [7:0] a, input logic [15:0] d);
    bus.req_a_valid = v; bus.req_a_we = we; bus.req_a_addr = a; bus.req_a_wdata = d;
  endtask

  task automatic set_b(input logic v, input logic we, input logic [7:0] a, input logic [15:0] d);
    bus.req_b_valid = v; bus.req_b_we = we; bus.req_b_addr = a; bus.req_b_wdata = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_init = 1'b1;
    set_a(0, 0, 8'h00, 16'h0); set_b(0, 0, 8'h00, 16'h0);
    cyc(); cyc();
    mem_init = 1'b0; rst = 1'b0;
    cyc();
    set_a(1, 0, 8'h10, 16'h0);
    cyc();
    set_a(0, 0, 8'h00, 16'h0);
    n_chk++; if (bus.ram_addr_a !== 8'h10) $display("FAIL rst_pre_addr_a got %h want 10", bus.ram_addr_a); else n_pass++;
    rst = 1'b1; #1;
    n_chk++; if (bus.ram_addr_a !== 8'h00) $display("FAIL rst_addr_a got %h want 00", bus.ram_addr_a); else n_pass++;
    n_chk++; if ({bus.ram_we_a, bus.ram_we_b} !== 2'b00) $display("FAIL rst_we got %b want 00", {bus.ram_we_a, bus.ram_we_b}); else n_pass++;
    n_chk++; if ({bus.ram_data_a, bus.ram_data_b} !== 32'h0) $display("FAIL rst_data got %h want 0", {bus.ram_data_a, bus.ram_data_b}); else n_pass++;
    set_a(1, 0, 8'h11, 16'h0); #1;
    n_chk++; if (bus.req_a_ready !== 1'b0) $display("FAIL rst_ready_a got %b want 0", bus.req_a_ready); else n_pass++;
    set_a(0, 0, 8'h00, 16'h0);
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (bus.rsp_a_valid !== 1'b0) $display("FAIL rst_no_rsp[%0d] got %b want 0", i, bus.rsp_a_valid); else n_pass++;
      cyc();
    end
    // pri restarts at A: a write/write conflict must go to A
    set_a(1, 1, 8'h40, 16'h1); set_b(1, 1, 8'h40, 16'h2); #1;
    n_chk++; if ({bus.req_a_ready, bus.req_b_ready} !== 2'b10) $display("FAIL rst_pri got %b want 10", {bus.req_a_ready, bus.req_b_ready}); else n_pass++;
    set_a(0, 0, 8'h00, 16'h0); set_b(0, 0, 8'h00, 16'h0);
  endtask

  task automatic test_write_read();
    cyc();
    set_a(1, 1, 8'h12, 16'hBEEF); #1;
    n_chk++; if (bus.req_a_ready !== 1'b1) $display("FAIL wr_ready_a got %b want 1", bus.req_a_ready); else n_pass++;
    cyc();
    n_chk++; if ({bus.ram_we_a, bus.ram_addr_a, bus.ram_data_a} !== {1'b1, 8'h12, 16'hBEEF})
      $display("FAIL wr_issue got %b/%h/%h want 1/12/beef", bus.ram_we_a, bus.ram_addr_a, bus.ram_data_a); else n_pass++;
    set_a(1, 0, 8'h12, 16'h0);
    cyc();
    set_a(0, 0, 8'h00, 16'h0);
    n_chk++; if (bus.ram_we_a !== 1'b0) $display("FAIL rd_issue_we got %b want 0", bus.ram_we_a); else n_pass++;
    n_chk++; if (bus.rsp_a_valid !== 1'b0) $display("FAIL rd_early got %b want 0", bus.rsp_a_valid); else n_pass++;
    cyc();
    n_chk++; if (bus.rsp_a_valid !== 1'b1) $display("FAIL rd_valid got %b want 1", bus.rsp_a_valid); else n_pass++;
    n_chk++; if (bus.rsp_a_rdata !== 16'hBEEF) $display("FAIL rd_data got %h want beef", bus.rsp_a_rdata); else n_pass++;
    cyc();
    n_chk++; if ({bus.rsp_a_valid, bus.rsp_a_rdata} !== 17'h0) $display("FAIL rd_gate got %b/%h want 0/0000", bus.rsp_a_valid, bus.rsp_a_rdata); else n_pass++;
  endtask

  task automatic test_parallel();
    set_a(1, 1, 8'h01, 16'h1111); set_b(1, 1, 8'h02, 16'h2222); #1;
    n_chk++; if ({bus.req_a_ready, bus.req_b_ready} !== 2'b11) $display("FAIL par_ready got %b want 11", {bus.req_a_ready, bus.req_b_ready}); else n_pass++;
    cyc();
    set_a(1, 0, 8'h01, 16'h0); set_b(1, 0, 8'h02, 16'h0);
    cyc();
    set_a(0, 0, 8'h00, 16'h0); set_b(0, 0, 8'h00, 16'h0);
    cyc();
    n_chk++; if ({bus.rsp_a_valid, bus.rsp_b_valid} !== 2'b11) $display("FAIL par_valid got %b want 11", {bus.rsp_a_valid, bus.rsp_b_valid}); else n_pass++;
    n_chk++; if (bus.rsp_a_rdata !== 16'h1111) $display("FAIL par_data_a got %h want 1111", bus.rsp_a_rdata); else n_pass++;
    n_chk++; if (bus.rsp_b_rdata !== 16'h2222) $display("FAIL par_data_b got %h want 2222", bus.rsp_b_rdata); else n_pass++;
  endtask

  task automatic test_same_read();
    set_a(1, 0, 8'h05, 16'h0); set_b(1, 0, 8'h05, 16'h0); #1;
    n_chk++; if ({bus.req_a_ready, bus.req_b_ready} !== 2'b11) $display("FAIL rr_ready got %b want 11", {bus.req_a_ready, bus.req_b_ready}); else n_pass++;
    cyc();
    set_a(0, 0, 8'h00, 16'h0); set_b(0, 0, 8'h00, 16'h0);
    cyc();
    n_chk++; if ({bus.rsp_a_valid, bus.rsp_b_valid} !== 2'b11) $display("FAIL rr_valid got %b want 11", {bus.rsp_a_valid, bus.rsp_b_valid}); else n_pass++;
    n_chk++; if ({bus.rsp_a_rdata, bus.rsp_b_rdata} !== 32'hA5A5A5A5) $display("FAIL rr_data got %h want a5a5a5a5", {bus.rsp_a_rdata, bus.rsp_b_rdata}); else n_pass++;
  endtask

  task automatic test_wr_rd_conflict();
    cyc();
    set_a(1, 1, 8'h20, 16'h5555); set_b(1, 0, 8'h20, 16'h0); #1;
    n_chk++; if ({bus.req_a_ready, bus.req_b_ready} !== 2'b10) $display("FAIL wrc_ready got %b want 10", {bus.req_a_ready, bus.req_b_ready}); else n_pass++;
    cyc();
    set_a(0, 0, 8'h00, 16'h0); #1;
    n_chk++; if (bus.req_b_ready !== 1'b1) $display("FAIL wrc_retry got %b want 1", bus.req_b_ready); else n_pass++;
    cyc();
    set_b(0, 0, 8'h00, 16'h0);
    n_chk++; if (bus.rsp_b_valid !== 1'b0) $display("FAIL wrc_early got %b want 0", bus.rsp_b_valid); else n_pass++;
    cyc();
    n_chk++; if (bus.rsp_b_valid !== 1'b1) $display("FAIL wrc_valid got %b want 1", bus.rsp_b_valid); else n_pass++;
    n_chk++; if (bus.rsp_b_rdata !== 16'h5555) $display("FAIL wrc_data got %h want 5555", bus.rsp_b_rdata); else n_pass++;
  endtask

  task automatic test_ww_conflict();
    logic [1:0] exp;
    cyc();
    rst = 1'b1; #1; rst = 1'b0;
    cyc();
    set_a(1, 1, 8'h30, 16'hAAAA); set_b(1, 1, 8'h30, 16'hBBBB);
    for (int i = 0; i < 4; i++) begin
      #1;
`ifdef DPRAM_RR_ARB_EN
      exp = (i % 2 == 0) ? 2'b10 : 2'b01;
`else
      exp = 2'b10;
`endif
      n_chk++; if ({bus.req_a_ready, bus.req_b_ready} !== exp)
        $display("FAIL ww_ready[%0d] got %b want %b", i, {bus.req_a_ready, bus.req_b_ready}, exp); else n_pass++;
      cyc();
    end
    set_a(0, 0, 8'h00, 16'h0); set_b(0, 0, 8'h00, 16'h0);
    cyc();
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    bus.req_a_valid = 1'b0; bus.req_b_valid = 1'b0;
    test_reset();
    test_write_read();
    test_parallel();
    test_same_read();
    test_wr_rd_conflict();
    test_ww_conflict();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dpram_port_ctrl.md
# dpram_port_ctrl

Request front-end for the dual-port 16-bit RAM (`clk`/`rst`, ports A and B, 8-bit addresses, 1-cycle registered read).
- Accepts independent valid/ready requests on two client ports and detects same-cycle same-address hazards between them.
- Serialises conflicting requests and drives the RAM's `addr_*`, `we_*` and `data_*` pins from registers.
- Returns read data to each client with a valid strobe.

## Interface
- ADDR_W, 8, address width; matches the RAM address pins.
- DATA_W, 16, data width; matches the RAM data pins.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_a_valid  in  1  port A request present.
- req_a_ready  out  1  port A request accepted this cycle.
- req_a_we  in  1  1 = write, 0 = read.
- req_a_addr  in  ADDR_W  port A address.
- req_a_wdata  in  DATA_W  port A write data.
- rsp_a_valid  out  1  port A read data valid.
- rsp_a_rdata  out  DATA_W  port A read data.
- req_b_*, rsp_b_*: same as the port A signals, for port B.
- ram_addr_a, ram_addr_b  out  ADDR_W  RAM addresses.
- ram_we_a, ram_we_b  out  1  RAM write enables.
- ram_data_a, ram_data_b  out  DATA_W  RAM write data.
- ram_dataout_a, ram_dataout_b  in  DATA_W  RAM registered read data.

## Operation
- Handshake: a request transfers at a rising edge when valid and ready are both 1.
  - valid/we/addr/wdata must hold until the transfer.
  - ready may depend combinationally on both ports' valid/addr/we.
- Conflict: both valid, addr_a == addr_b, and at least one we = 1.
  - Two reads of the same address are not a conflict; both are accepted.
- No conflict: ready = 1 on both ports.
- Conflict: the winner's ready = 1 and the loser's ready = 0. The loser re-arbitrates next cycle.
- Winner selection: priority pointer `pri` (0 = A, 1 = B); see Configuration.
- Issue stage (registered): an accepted request loads ram_addr/ram_we/ram_data for its port.
  - A port with no transfer drives ram_we = 0, ram_data = 0, and holds ram_addr.
- Read tracking: a per-port flag records "read issued". At the next edge, rsp_valid is set from that flag.
  - rsp_rdata = ram_dataout of that port, passed through combinationally, gated to 0 when rsp_valid = 0.
- No response backpressure: clients must sink rsp every cycle.
- Ordering: because the RAM write lands at the issue edge, a read that loses to a same-address write returns the new data.
- Reset (asynchronous, any time):
  - All ram_* outputs, rsp_valid and rsp_rdata gating go to 0; `pri` = 0.
  - In-flight reads are dropped and produce no rsp_valid.
  - ready is 0 while rst = 1.

## Timing
- Handshake at edge E0 → ram_* valid after E0 → RAM samples at E1 → rsp_valid = 1 in the cycle after E1.
  - Read latency: 2 cycles from handshake. Write completes at E1.
- Throughput: one request per port per cycle when there is no conflict.
- A conflict costs the loser exactly 1 cycle if the winner does not re-present the same conflicting request.
- Back-to-back reads on one port produce back-to-back rsp_valid.

## Configuration
- DPRAM_RR_ARB_EN defined: round-robin.
  - On a conflict, the winner = `pri`; at that edge `pri` flips to the loser.
  - Neither port can be starved for more than 1 consecutive conflict.
- Not defined: fixed priority. Port A always wins conflicts, `pri` is a constant 0, and port B may be starved indefinitely.

## Structure
- Package dpram_ctrl_pkg:
  - ADDR_W/DATA_W defaults.
  - Request struct typedef (we, addr, wdata).
  - Port select enum (PORT_A, PORT_B).
- Sub-module dpram_conflict_arb:
  - Combinational conflict detection, ready generation, and the `pri` register.
  - The `pri` register and its macro-dependent update live here.
- Top level holds the issue registers and read-tracking flags.

## Test plan
- Reset: assert rst mid-read (handshake A read addr 0x10, rst before the response) → rsp_a_valid never asserts; all ram_* = 0; `pri` = 0.
- Write then read: A writes 0x12 with 0xBEEF, then A reads 0x12 → rsp_a_rdata = 0xBEEF, rsp_a_valid = 1 two cycles after the read handshake.
- Parallel no-conflict: A writes 0x01 with 0x1111 and B writes 0x02 with 0x2222 in the same cycle → both ready = 1. Subsequent reads of 0x01/0x02 return 0x1111/0x2222.
- Same-address reads: both read 0x05 (preloaded 0xA5A5) → both ready = 1; both rsp_valid = 1 in the same cycle with 0xA5A5.
- Write/read conflict: A writes 0x20 with 0x5555 while B reads 0x20 (old 0x0000) → A accepted, B ready = 0 for 1 cycle. B then returns 0x5555.
- Sustained write-write conflict on 0x30 for 4 cycles:
  - With DPRAM_RR_ARB_EN: acceptances alternate A, B, A, B.
  - Without it: A is accepted every cycle and B never is.
